// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one registered one-hot grant per cycle among pre-masked requests.
// Define RR_ARBITER_ASSERT_EN to compile in simulation-only protocol assertions.
module rr_arbiter #(
   parameter int unsigned num_reqs = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [num_reqs-1:0] reqs,
   output logic [num_reqs-1:0] grants
);

   localparam int unsigned        PW   = (num_reqs > 1) ? $clog2(num_reqs) : 1;
   localparam logic [PW-1:0]       LAST = PW'(num_reqs - 1);
   localparam logic [PW-1:0]       PONE = PW'(1);
   localparam logic [num_reqs-1:0] ONE  = num_reqs'(1);

   logic [num_reqs-1:0] r_grants;
   logic [PW-1:0]       r_ptr;

   logic [num_reqs-1:0] w_mask;
   logic [num_reqs-1:0] w_hi;
   logic [num_reqs-1:0] w_cand;
   logic [num_reqs-1:0] w_onehot;
   logic [PW-1:0]       w_win;
   logic [PW-1:0]       w_next_ptr;
   logic                w_any;

   // Circular scan from r_ptr: prefer the lowest set bit at or above r_ptr,
   // otherwise wrap to the lowest set bit overall.
   always_comb begin
      w_mask = '0;
      for (int unsigned i = 0; i < num_reqs; i++) begin
         w_mask[i] = (PW'(i) >= r_ptr);
      end
      w_hi     = reqs & w_mask;
      w_cand   = (|w_hi) ? w_hi : reqs;
      w_onehot = w_cand & ~(w_cand - ONE);
      w_win    = '0;
      for (int unsigned i = 0; i < num_reqs; i++) begin
         if (w_onehot[i]) begin
            w_win = PW'(i);
         end
      end
      w_next_ptr = (w_win == LAST) ? '0 : w_win + PONE;
      w_any      = |reqs;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_grants <= '0;
         r_ptr    <= '0;
      end else if (w_any) begin
         r_grants <= w_onehot;
         r_ptr    <= w_next_ptr;
      end else begin
         r_grants <= '0;
      end
   end

   assign grants = r_grants;

`ifdef RR_ARBITER_ASSERT_EN
   a_onehot: assert property (@(posedge clk) disable iff (reset)
      $onehot0(grants));

   a_grant_had_req: assert property (@(posedge clk) disable iff (reset)
      !$past(reset) |-> ((grants & ~$past(reqs)) == '0));

   a_req_gets_grant: assert property (@(posedge clk) disable iff (reset)
      (!$past(reset) && (|$past(reqs))) |-> (grants != '0));
`else
`endif

endmodule

// File: tb/tb_rr_arbiter.sv
// Scoreboard bench for rr_arbiter: a circular-scan reference model predicts each grant,
// plus a num_reqs=1 instance checked as a one-cycle delay of its request.
module tb_rr_arbiter;

   logic       clk;
   logic       reset;
   logic [3:0] reqs;
   logic [3:0] grants;
   logic [0:0] reqs1;
   logic [0:0] grants1;

   int unsigned n_checks;
   int unsigned n_errors;

   logic [3:0] exp_q [$];
   int unsigned m_ptr;

   rr_arbiter #(.num_reqs(4)) u_dut (
      .clk    (clk),
      .reset  (reset),
      .reqs   (reqs),
      .grants (grants)
   );

   rr_arbiter #(.num_reqs(1)) u_dut1 (
      .clk    (clk),
      .reset  (reset),
      .reqs   (reqs1),
      .grants (grants1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [3:0] got, input logic [3:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %b exp %b", tag, got, exp);
      end
   endtask

   // Reference model: explicit modulo scan starting at the priority pointer.
   function automatic logic [3:0] model_next(input logic rst, input logic [3:0] r);
      logic [3:0] g;
      logic       found;
      int unsigned idx;
      g     = 4'b0000;
      found = 1'b0;
      if (rst) begin
         m_ptr = 0;
      end else begin
         for (int unsigned k = 0; k < 4; k++) begin
            idx = (m_ptr + k) % 4;
            if (!found && r[idx]) begin
               found  = 1'b1;
               g[idx] = 1'b1;
               m_ptr  = (idx + 1) % 4;
            end
         end
      end
      return g;
   endfunction

   task automatic step(input logic rst, input logic [3:0] r);
      logic [3:0] exp;
      logic [3:0] exp1;
      exp_q.push_back(model_next(rst, r));
      exp1  = {3'b000, (rst ? 1'b0 : r[0])};
      reset = rst;
      reqs  = r;
      reqs1 = r[0];
      @(posedge clk);
      #1;
      exp = exp_q.pop_front();
      check_eq("grant", grants, exp);
      check_eq("n1_grant", {3'b000, grants1}, exp1);
   endtask

   logic [3:0] contention [8];

   initial begin
      n_checks = 0;
      n_errors = 0;
      m_ptr    = 0;
      reset    = 1'b1;
      reqs     = 4'b0000;
      reqs1    = 1'b0;
      contention = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                     4'b0001, 4'b0010, 4'b0100, 4'b1000};
      @(posedge clk);
      #1;

      // Reset held with all requests asserted
      step(1'b1, 4'b1111);
      check_eq("rst_hold0", grants, 4'b0000);
      step(1'b1, 4'b1111);
      check_eq("rst_hold1", grants, 4'b0000);

      // Full contention: strict rotation
      for (int unsigned i = 0; i < 8; i++) begin
         step(1'b0, 4'b1111);
         check_eq("contend", grants, contention[i]);
      end

      // Sparse requests wrapping past the top index
      step(1'b0, 4'b0100);
      check_eq("sparse_pre", grants, 4'b0100);
      step(1'b0, 4'b0101);
      check_eq("sparse_wrap", grants, 4'b0001);
      step(1'b0, 4'b0101);
      check_eq("sparse_next", grants, 4'b0100);

      // Idle cycles keep the pointer
      step(1'b0, 4'b0010);
      check_eq("idle_pre", grants, 4'b0010);
      for (int unsigned i = 0; i < 3; i++) begin
         step(1'b0, 4'b0000);
         check_eq("idle", grants, 4'b0000);
      end
      step(1'b0, 4'b0011);
      check_eq("idle_wrap", grants, 4'b0001);

      // Sole continuous requester
      for (int unsigned i = 0; i < 3; i++) begin
         step(1'b0, 4'b1000);
         check_eq("single", grants, 4'b1000);
      end

      // Reset in the middle of rotation
      step(1'b0, 4'b1111);
      check_eq("mid_a", grants, 4'b0001);
      step(1'b0, 4'b1111);
      check_eq("mid_b", grants, 4'b0010);
      step(1'b0, 4'b1111);
      check_eq("mid_c", grants, 4'b0100);
      step(1'b1, 4'b1111);
      check_eq("mid_rst", grants, 4'b0000);
      step(1'b0, 4'b1111);
      check_eq("mid_restart", grants, 4'b0001);

      // Random traffic, including dropped requests and occasional reset
      for (int unsigned i = 0; i < 300; i++) begin
         step(($urandom_range(0, 24) == 0), 4'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
